// File: rtl/mack_decoder_v3.sv
// Mackerel 68000 address decoder and bus-cycle controller: chip selects, ROM boot
// overlay, wait-state DTACK generation, MFP DTACK pass-through and BERR timeout.
module mack_decoder_v3 #(
    parameter int                       SEL_HI       = 21,
    parameter int                       SEL_LO       = 19,
    parameter logic [SEL_HI-SEL_LO:0]   ROM_SEL      = 3'b111,
    parameter logic [SEL_HI-SEL_LO:0]   MFP_SEL      = 3'b110,
    parameter logic [SEL_HI-SEL_LO:0]   RAM_SEL      = 3'b000,
    parameter int                       BOOT_CYCLES  = 8,
    parameter int                       ROM_WAIT     = 2,
    parameter int                       RAM_WAIT     = 0,
    parameter int                       BERR_TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [23:15] addr_i,
    input  logic         as_ni,
    input  logic         iack_ni,
    input  logic         dtack_ni,
    output logic         romen_no,
    output logic         ramen_no,
    output logic         mfpen_no,
    output logic         dtack_no,
    output logic         berr_no,
    output logic         boot_o
);

    localparam int          W        = SEL_HI - SEL_LO + 1;
    localparam logic [7:0]  BOOT_N   = 8'(BOOT_CYCLES);
    localparam logic [3:0]  ROM_W    = 4'(ROM_WAIT);
    localparam logic [3:0]  RAM_W    = 4'(RAM_WAIT);
    localparam logic [9:0]  TMO_LAST = 10'(BERR_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_FAULT
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [9:0]  tcnt_q, tcnt_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic        boot_q, boot_d;
    logic        dtack_q, dtack_d;
    logic        berr_q, berr_d;
    logic        as_q;
    logic        din_q;

    logic [W-1:0] field;
    logic         strobe, iack_cyc;
    logic         rom_sel, ram_sel, mfp_sel, mem_sel;
    logic         as_rise;
    logic         ack_now;
    logic         unused_addr;

    // Only the select field of the address participates in decoding.
    assign unused_addr = ^addr_i;

    assign field    = addr_i[SEL_HI:SEL_LO];
    assign strobe   = ~as_ni;
    assign iack_cyc = ~iack_ni;

    // During the overlay every non-IACK access goes to ROM.
    assign rom_sel = strobe & ~iack_cyc & (~boot_q | (field == ROM_SEL));
    assign ram_sel = strobe & ~iack_cyc & boot_q & (field == RAM_SEL);
    assign mfp_sel = strobe & (iack_cyc | (boot_q & (field == MFP_SEL)));
    assign mem_sel = rom_sel | ram_sel;

    assign romen_no = ~rom_sel;
    assign ramen_no = ~ram_sel;
    assign mfpen_no = ~mfp_sel;
    assign dtack_no = dtack_q;
    assign berr_no  = berr_q;
    assign boot_o   = boot_q;

    assign as_rise = as_ni & ~as_q;

    // Boot overlay counter: one count per completed bus cycle.
    always_comb begin
        bcnt_d = bcnt_q;
        boot_d = boot_q;
        if (as_rise && !boot_q) begin
            bcnt_d = bcnt_q + 8'd1;
            if (bcnt_q + 8'd1 == BOOT_N) begin
                boot_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        dtack_d = dtack_q;
        berr_d  = berr_q;
        ack_now = 1'b0;
        if (as_ni) begin
            // End of cycle, or an aborted one: release everything.
            state_d = S_IDLE;
            dtack_d = 1'b1;
            berr_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (as_q) begin
                        state_d = S_WAIT;
                        tcnt_d  = '0;
                        if (rom_sel)      wcnt_d = ROM_W;
                        else if (ram_sel) wcnt_d = RAM_W;
                        else              wcnt_d = '0;
                    end
                end
                S_WAIT: begin
                    if (mem_sel)      ack_now = (wcnt_q == 4'd0);
                    else if (mfp_sel) ack_now = ~din_q;
                    tcnt_d = tcnt_q + 10'd1;
                    // An ack on the timeout edge takes priority over BERR.
                    if (ack_now) begin
                        state_d = S_ACK;
                        dtack_d = 1'b0;
                    end else if (tcnt_q == TMO_LAST) begin
                        state_d = S_FAULT;
                        berr_d  = 1'b0;
                    end else if (mem_sel) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
                S_ACK, S_FAULT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            boot_q  <= 1'b0;
            dtack_q <= 1'b1;
            berr_q  <= 1'b1;
            as_q    <= 1'b1;
            din_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            boot_q  <= boot_d;
            dtack_q <= dtack_d;
            berr_q  <= berr_d;
            as_q    <= as_ni;
            din_q   <= dtack_ni;
        end
    end

endmodule

// File: tb/tb_mack_decoder_v3.sv
// Randomised and directed bench for mack_decoder_v3 against a cycle-level
// behavioural model of chip selects, ack/timeout edges and the boot overlay.
module tb_mack_decoder_v3;

    localparam int T     = 64;
    localparam int RW    = 2;
    localparam int AW    = 0;
    localparam int BC    = 8;
    localparam int NEVER = 100000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [23:15] addr = '0;
    logic         as_n = 1'b1;
    logic         iack_n = 1'b1;
    logic         din_n = 1'b1;
    logic         romen_n, ramen_n, mfpen_n, dtack_n, berr_n, boot;

    int checks = 0;
    int errors = 0;

    // model state: overlay status and completed-cycle count
    bit m_boot;
    int m_cnt;

    // observations of the last bus cycle
    logic [2:0] c_sel, c_idle;
    int         c_dt, c_bt;
    logic       c_rel_dt, c_rel_bt, c_boot;

    always #5 clk = ~clk;

    mack_decoder_v3 dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .addr_i   (addr),
        .as_ni    (as_n),
        .iack_ni  (iack_n),
        .dtack_ni (din_n),
        .romen_no (romen_n),
        .ramen_no (ramen_n),
        .mfpen_no (mfpen_n),
        .dtack_no (dtack_n),
        .berr_no  (berr_n),
        .boot_o   (boot)
    );

    // Expected active-low {ROMEN,RAMEN,MFPEN} while AS is low.
    function automatic logic [2:0] exp_sel(logic [23:0] a, bit iack, bit bt);
        logic [2:0] f;
        f = a[21:19];
        if (iack) return 3'b110;
        if (!bt) return 3'b011;
        case (f)
            3'b111:  return 3'b011;
            3'b000:  return 3'b101;
            3'b110:  return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    // Edge index (relative to E0) at which the cycle would be acknowledged.
    function automatic int exp_ack(logic [2:0] sel, int j);
        if (sel == 3'b011) return 1 + RW;
        if (sel == 3'b101) return 1 + AW;
        if (sel == 3'b110) return (j >= NEVER) ? NEVER : j + 1;
        return NEVER;
    endfunction

    function automatic int exp_dt(int ea, int hold);
        return (ea <= T && ea <= hold) ? ea : -1;
    endfunction

    function automatic int exp_bt(int ea, int hold);
        return (ea > T && T <= hold) ? T : -1;
    endfunction

    task automatic mdl_rise();
        if (!m_boot) begin
            m_cnt++;
            if (m_cnt == BC) m_boot = 1'b1;
        end
    endtask

    // One bus cycle: AS low for E0 plus `hold` edges, DTACK_IN low from edge j.
    task automatic run_cycle(input logic [23:0] a, input bit iack, input int hold, input int j);
        @(negedge clk);
        c_idle = {romen_n, ramen_n, mfpen_n};
        addr   = a[23:15];
        iack_n = ~iack;
        as_n   = 1'b0;
        din_n  = 1'b1;
        #1 c_sel = {romen_n, ramen_n, mfpen_n};
        c_dt = -1;
        c_bt = -1;
        @(posedge clk);
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            din_n = (k >= j) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (c_dt < 0 && dtack_n === 1'b0) c_dt = k;
            if (c_bt < 0 && berr_n === 1'b0) c_bt = k;
        end
        @(negedge clk);
        as_n   = 1'b1;
        din_n  = 1'b1;
        iack_n = 1'b1;
        @(posedge clk);
        #1;
        c_rel_dt = dtack_n;
        c_rel_bt = berr_n;
        c_boot   = boot;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_boot = 1'b0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dtack_n, berr_n, boot, romen_n, ramen_n, mfpen_n} !== 6'b110111) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", {dtack_n, berr_n, boot, romen_n, ramen_n, mfpen_n}, 6'b110111);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midcycle();
        for (int n = 0; n < 2; n++) begin
            run_cycle(24'h000000, 1'b0, 4, NEVER);
            mdl_rise();
            checks++;
            if (c_dt != 3 || c_boot !== m_boot) begin
                errors++;
                $display("FAIL mid_pre cyc=%0d dt=%0d boot=%b exp dt=3 boot=%b", n, c_dt, c_boot, m_boot);
            end
        end
        @(negedge clk);
        addr = '0;
        as_n = 1'b0;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (dtack_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_ack got=%b exp=0", dtack_n);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dtack_n, berr_n, boot} !== 3'b110) begin
            errors++;
            $display("FAIL mid_async got=%b exp=110", {dtack_n, berr_n, boot});
        end
        as_n = 1'b1;
        m_boot = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_boot_overlay();
        logic [2:0] es;
        int ea;
        for (int n = 0; n < BC + 1; n++) begin
            run_cycle(24'h000000, 1'b0, 4, NEVER);
            es = exp_sel(24'h000000, 1'b0, m_boot);
            ea = exp_ack(es, NEVER);
            mdl_rise();
            checks++;
            if (c_sel !== es || c_idle !== 3'b111) begin
                errors++;
                $display("FAIL boot_sel cyc=%0d got=%b exp=%b idle=%b", n, c_sel, es, c_idle);
            end
            checks++;
            if (c_dt != exp_dt(ea, 4) || c_boot !== m_boot || c_rel_dt !== 1'b1) begin
                errors++;
                $display("FAIL boot_cyc cyc=%0d dt=%0d boot=%b rel=%b exp dt=%0d boot=%b rel=1",
                         n, c_dt, c_boot, c_rel_dt, exp_dt(ea, 4), m_boot);
            end
        end
    endtask

    // Directed table: address, iack, hold, DTACK_IN edge.
    task automatic test_directed(input string nm, input logic [23:0] a, input bit iack,
                                 input int hold, input int j);
        logic [2:0] es;
        int ea;
        run_cycle(a, iack, hold, j);
        es = exp_sel(a, iack, m_boot);
        ea = exp_ack(es, j);
        mdl_rise();
        checks++;
        if (c_sel !== es) begin
            errors++;
            $display("FAIL %s_sel got=%b exp=%b", nm, c_sel, es);
        end
        checks++;
        if (c_dt != exp_dt(ea, hold) || c_bt != exp_bt(ea, hold) ||
            c_rel_dt !== 1'b1 || c_rel_bt !== 1'b1 || c_boot !== m_boot) begin
            errors++;
            $display("FAIL %s_timing dt=%0d bt=%0d rel=%b%b boot=%b exp dt=%0d bt=%0d rel=11 boot=%b",
                     nm, c_dt, c_bt, c_rel_dt, c_rel_bt, c_boot, exp_dt(ea, hold), exp_bt(ea, hold), m_boot);
        end
    endtask

    task automatic test_random();
        logic [23:0] a;
        bit iack;
        int hold, j, ea;
        logic [2:0] es;
        for (int n = 0; n < 30; n++) begin
            a    = {$urandom_range(0, 7)} << 19 | ($urandom & 24'h07FFFF);
            iack = ($urandom_range(0, 5) == 0);
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 68) : $urandom_range(1, 12);
            j    = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(1, 10);
            run_cycle(a, iack, hold, j);
            es = exp_sel(a, iack, m_boot);
            ea = exp_ack(es, j);
            mdl_rise();
            checks++;
            if (c_sel !== es) begin
                errors++;
                $display("FAIL rnd_sel n=%0d a=%h iack=%b got=%b exp=%b", n, a, iack, c_sel, es);
            end
            checks++;
            if (c_dt != exp_dt(ea, hold) || c_bt != exp_bt(ea, hold) ||
                c_rel_dt !== 1'b1 || c_rel_bt !== 1'b1 || c_boot !== m_boot) begin
                errors++;
                $display("FAIL rnd_timing n=%0d a=%h hold=%0d j=%0d dt=%0d bt=%0d rel=%b%b exp dt=%0d bt=%0d",
                         n, a, hold, j, c_dt, c_bt, c_rel_dt, c_rel_bt, exp_dt(ea, hold), exp_bt(ea, hold));
            end
        end
    endtask

    task automatic test_reset_after_boot();
        rst_n = 1'b0;
        #1;
        checks++;
        if (boot !== 1'b0 || m_boot !== 1'b1) begin
            errors++;
            $display("FAIL reset_boot got=%b exp=0 (model boot before=%b)", boot, m_boot);
        end
        m_boot = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_midcycle();
        test_boot_overlay();
        test_directed("rom_wait", 24'h380000, 1'b0, 5, NEVER);
        test_directed("ram_wait", 24'h000000, 1'b0, 3, NEVER);
        test_directed("mfp",      24'h300000, 1'b0, 8, 5);
        test_directed("unmapped", 24'h080000, 1'b0, 66, NEVER);
        test_directed("mfp_tmo",  24'h300000, 1'b0, 66, NEVER);
        test_directed("ack_wins", 24'h300000, 1'b0, 66, 63);
        test_directed("tmo_edge", 24'h300000, 1'b0, 66, 64);
        test_directed("iack",     24'h3A0000, 1'b1, 6, 3);
        test_directed("abort",    24'h380000, 1'b0, 2, NEVER);
        test_random();
        test_reset_after_boot();
        test_directed("iack_boot", 24'h000000, 1'b1, 5, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
